// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler that shares the 8:1 MUX / 1:8 DMX datapath between requesting channels.
// Drives the shared addr bus and a one-hot grant, holding each grant for at most BURST_LEN cycles.
module mux_rr_scheduler #(
    parameter int ADDR_W    = 3,
    parameter int BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2**ADDR_W-1:0]   req,
    output logic [2**ADDR_W-1:0]   grant,
    output logic [ADDR_W-1:0]      addr,
    output logic                   addrValid,
    output logic                   busy
);

    localparam int N_CH  = 2**ADDR_W;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} stateT;

    stateT              state, stateNext;
    logic [ADDR_W-1:0]  rrPtr, rrPtrNext;
    logic [CNT_W-1:0]   burstCnt, burstCntNext;
    logic [N_CH-1:0]    grantNext;
    logic [ADDR_W-1:0]  addrNext;
    logic               addrValidNext;
    logic               busyNext;

    logic [ADDR_W-1:0]  winner;
    logic [ADDR_W-1:0]  idx;
    logic               found;
    logic [N_CH-1:0]    winnerOneHot;

    // Scan channels starting at rrPtr and wrapping; the first requester wins.
    always_comb begin
        winner       = '0;
        idx          = '0;
        found        = 1'b0;
        winnerOneHot = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = rrPtr + ADDR_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        winnerOneHot[winner] = 1'b1;
    end

    always_comb begin
        stateNext     = state;
        rrPtrNext     = rrPtr;
        burstCntNext  = burstCnt;
        grantNext     = grant;
        addrNext      = addr;
        addrValidNext = addrValid;
        unique case (state)
            IDLE, RELEASE: begin
                // addr keeps its last value when nobody is granted so the MUX output stays stable
                if (found) begin
                    stateNext     = GRANT;
                    addrNext      = winner;
                    grantNext     = winnerOneHot;
                    addrValidNext = 1'b1;
                    burstCntNext  = CNT_W'(1);
                end else begin
                    stateNext     = IDLE;
                    grantNext     = '0;
                    addrValidNext = 1'b0;
                end
            end
            GRANT: begin
                if (req[addr] && (burstCnt < CNT_W'(BURST_LEN))) begin
                    burstCntNext = burstCnt + CNT_W'(1);
                end else begin
                    stateNext     = RELEASE;
                    rrPtrNext     = addr + ADDR_W'(1);
                    grantNext     = '0;
                    addrValidNext = 1'b0;
                end
            end
            default: begin
                stateNext     = IDLE;
                grantNext     = '0;
                addrValidNext = 1'b0;
            end
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rrPtr     <= '0;
            burstCnt  <= '0;
            grant     <= '0;
            addr      <= '0;
            addrValid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            rrPtr     <= rrPtrNext;
            burstCnt  <= burstCntNext;
            grant     <= grantNext;
            addr      <= addrNext;
            addrValid <= addrValidNext;
            busy      <= busyNext;
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: directed request patterns push the expected
// (cycle, channel) of every granted cycle; a negedge monitor pops and compares them.
module tb_mux_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] addr;
    logic       addrValid;
    logic       busy;

    int checkCount = 0;
    int errorCount = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int ch;
    } expT;

    expT expQ[$];
    expT monExp;

    mux_rr_scheduler #(.ADDR_W(3), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .addr      (addr),
        .addrValid (addrValid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r);
        req = r;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One queue entry per cycle in which the channel is expected to hold the grant.
    task automatic expectGrant(input int ch, input int startCyc, input int len);
        expT e;
        for (int i = 0; i < len; i++) begin
            e.cyc = startCyc + i;
            e.ch  = ch;
            expQ.push_back(e);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Grant"}, int'(grant), 0);
        checkOutput({tag, "Addr"}, int'(addr), 0);
        checkOutput({tag, "AddrValid"}, int'(addrValid), 0);
        checkOutput({tag, "Busy"}, int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (addrValid) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedGrant: got addr %0d grant %0h at cycle %0d, expected no grant",
                             addr, grant, cyc);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("grantCycle", cyc, monExp.cyc);
                    checkOutput("grantAddr", int'(addr), monExp.ch);
                    checkOutput("grantOneHot", int'(grant), 1 << monExp.ch);
                end
            end else begin
                checkOutput("noGrantWhenInvalid", int'(grant), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;

        // Reset held with every channel requesting
        rst_n = 1'b0;
        req   = 8'hFF;
        #3;
        checkIdleOutputs("resetHeld");
        waitEdges(2);
        checkIdleOutputs("resetAfterEdges");
        rst_n = 1'b1;
        applyStimulus(8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkIdleOutputs("idleNoReq");
        end

        // Sole requester on channel 3, held 12 edges
        waitEdges(1);
        c = cyc;
        applyStimulus(8'h08);
        expectGrant(3, c + 1, 4);
        expectGrant(3, c + 6, 4);
        expectGrant(3, c + 11, 2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("gapAddrHeld", int'(addr), 3);
        checkOutput("gapAddrValid", int'(addrValid), 0);
        checkOutput("gapBusy", int'(busy), 1);
        checkOutput("gapGrant", int'(grant), 0);
        waitEdges(7);
        applyStimulus(8'h00);
        waitEdges(3);
        checkOutput("soleDoneBusy", int'(busy), 0);

        // All channels requesting from a fresh rrPtr
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        c = cyc;
        applyStimulus(8'hFF);
        for (int k = 0; k < 8; k++) expectGrant(k, c + 1 + 5 * k, 4);
        expectGrant(0, c + 41, 4);
        waitEdges(44);
        applyStimulus(8'h00);
        waitEdges(3);

        // Early drop on ch5, then ch6 wins from rrPtr=6, then wrap to ch0 and ch2
        c = cyc;
        applyStimulus(8'h20);
        expectGrant(5, c + 1, 2);
        waitEdges(2);
        applyStimulus(8'h00);
        waitEdges(1);
        applyStimulus(8'h41);
        expectGrant(6, c + 4, 4);
        waitEdges(4);
        applyStimulus(8'h05);
        expectGrant(0, c + 9, 4);
        expectGrant(2, c + 14, 4);
        waitEdges(10);
        applyStimulus(8'h00);
        waitEdges(3);

        // Asynchronous reset mid-grant, then rrPtr must be back at 0
        c = cyc;
        applyStimulus(8'h08);
        expectGrant(3, c + 1, 1);
        waitEdges(2);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("asyncReset");
        waitEdges(1);
        applyStimulus(8'h09);
        rst_n = 1'b1;
        c = cyc;
        expectGrant(0, c + 1, 1);
        waitEdges(1);
        applyStimulus(8'h00);
        waitEdges(3);
        checkOutput("finalBusy", int'(busy), 0);

        checkOutput("pendingGrants", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
